// File: rtl/decoder_pipe.sv
// decoder_pipe: RV32 instruction decoder feeding a DEPTH-entry circular queue
// of fully decoded records; every record output comes from the queue head.
// Optional feature macro: DECODER_M_EXT_EN (decode R-type funct7=0000001 as an
// M-extension op instead of flagging it illegal).
//
// One-hot layouts:
//   alu       : 0 ADD 1 SUB 2 SLT 3 SLTU 4 XOR 5 OR 6 AND 7 SLL 8 SRL 9 SRA
//               10 EQ 11 NEQ 12 GE 13 GEU   (BLT uses SLT, BLTU uses SLTU)
//   opcode    : 0 RTYPE 1 ITYPE 2 LOAD 3 STORE 4 BRANCH 5 JAL 6 JALR 7 LUI
//               8 AUIPC 9 SYSTEM 10 FENCE
//   exception : 0 ILLEGAL 1 ECALL 2 EBREAK 3 MRET
//
// Handshake: an input beat transfers on a clock edge where dp_i_valid and
// dp_o_ready are both high; the head transfers where dp_o_valid and dp_i_ready
// are both high. dp_o_ready and dp_o_valid depend only on registered
// occupancy, and the head record stays stable until it transfers.

`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module decoder_pipe #(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 5,
    parameter int DEPTH  = 4
) (
    input  logic                        dp_clk,
    input  logic                        dp_rst,
    input  logic                        dp_i_valid,
    output logic                        dp_o_ready,
    input  logic [31:0]                 dp_i_instr,
    input  logic [XLEN-1:0]             dp_i_pc,
    output logic                        dp_o_valid,
    input  logic                        dp_i_ready,
    input  logic                        dp_i_flush,
    output logic [XLEN-1:0]             dp_o_pc,
    output logic [AWIDTH-1:0]           dp_o_addr_rs1,
    output logic [AWIDTH-1:0]           dp_o_addr_rs2,
    output logic [AWIDTH-1:0]           dp_o_addr_rd,
    output logic [XLEN-1:0]             dp_o_imm,
    output logic [2:0]                  dp_o_funct3,
    output logic [`ALU_WIDTH-1:0]       dp_o_alu,
    output logic [`OPCODE_WIDTH-1:0]    dp_o_opcode,
    output logic [`EXCEPTION_WIDTH-1:0] dp_o_exception,
    output logic                        dp_o_muldiv,
    output logic [$clog2(DEPTH):0]      dp_o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3, ALU_XOR = 4;
    localparam int ALU_OR = 5, ALU_AND = 6, ALU_SLL = 7, ALU_SRL = 8, ALU_SRA = 9;
    localparam int ALU_EQ = 10, ALU_NEQ = 11, ALU_GE = 12, ALU_GEU = 13;

    localparam int OPC_R = 0, OPC_I = 1, OPC_LOAD = 2, OPC_STORE = 3, OPC_BRANCH = 4;
    localparam int OPC_JAL = 5, OPC_JALR = 6, OPC_LUI = 7, OPC_AUIPC = 8;
    localparam int OPC_SYSTEM = 9, OPC_FENCE = 10;

    localparam int EXC_ILLEGAL = 0, EXC_ECALL = 1, EXC_EBREAK = 2, EXC_MRET = 3;

    typedef struct packed {
        logic [XLEN-1:0]             pc;
        logic [AWIDTH-1:0]           rs1;
        logic [AWIDTH-1:0]           rs2;
        logic [AWIDTH-1:0]           rd;
        logic [XLEN-1:0]             imm;
        logic [2:0]                  funct3;
        logic [`ALU_WIDTH-1:0]       alu;
        logic [`OPCODE_WIDTH-1:0]    opcode;
        logic [`EXCEPTION_WIDTH-1:0] exception;
        logic                        muldiv;
    } rec_t;

    rec_t              dec;
    rec_t              head;
    rec_t              mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              push;
    logic              pop;

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

    assign opc = dp_i_instr[6:0];
    assign f3  = dp_i_instr[14:12];
    assign f7  = dp_i_instr[31:25];

    // Raw immediates are assembled at 32 bits, then sign- or zero-extended to XLEN.
    assign imm_i = XLEN'($signed(dp_i_instr[31:20]));
    assign imm_s = XLEN'($signed({dp_i_instr[31:25], dp_i_instr[11:7]}));
    assign imm_b = XLEN'($signed({dp_i_instr[31], dp_i_instr[7], dp_i_instr[30:25],
                                  dp_i_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({dp_i_instr[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({dp_i_instr[31], dp_i_instr[19:12], dp_i_instr[20],
                                  dp_i_instr[30:21], 1'b0}));
    assign imm_z = XLEN'(dp_i_instr[31:20]);

    // Arithmetic ALU select; SUB only when the caller allows it (R-type).
    function automatic logic [`ALU_WIDTH-1:0] alu_arith(input logic [2:0] fn,
                                                        input logic use_sub,
                                                        input logic use_sra);
        logic [`ALU_WIDTH-1:0] a;
        a = '0;
        case (fn)
            3'b000:  a[use_sub ? ALU_SUB : ALU_ADD] = 1'b1;
            3'b001:  a[ALU_SLL] = 1'b1;
            3'b010:  a[ALU_SLT] = 1'b1;
            3'b011:  a[ALU_SLTU] = 1'b1;
            3'b100:  a[ALU_XOR] = 1'b1;
            3'b101:  a[use_sra ? ALU_SRA : ALU_SRL] = 1'b1;
            3'b110:  a[ALU_OR] = 1'b1;
            default: a[ALU_AND] = 1'b1;
        endcase
        return a;
    endfunction

    // Branch comparison select; reserved funct3 values 010/011 select nothing.
    function automatic logic [`ALU_WIDTH-1:0] alu_branch(input logic [2:0] fn);
        logic [`ALU_WIDTH-1:0] a;
        a = '0;
        case (fn)
            3'b000:  a[ALU_EQ] = 1'b1;
            3'b001:  a[ALU_NEQ] = 1'b1;
            3'b100:  a[ALU_SLT] = 1'b1;
            3'b101:  a[ALU_GE] = 1'b1;
            3'b110:  a[ALU_SLTU] = 1'b1;
            3'b111:  a[ALU_GEU] = 1'b1;
            default: a = '0;
        endcase
        return a;
    endfunction

    // Combinational decode of the incoming instruction into a full record.
    always_comb begin
        dec        = '0;
        dec.pc     = dp_i_pc;
        dec.alu    = '0;
        dec.alu[ALU_ADD] = 1'b1;
        case (opc)
            7'b0110011: begin
                dec.rs1    = AWIDTH'(dp_i_instr[19:15]);
                dec.rs2    = AWIDTH'(dp_i_instr[24:20]);
                dec.rd     = AWIDTH'(dp_i_instr[11:7]);
                dec.funct3 = f3;
                dec.opcode[OPC_R] = 1'b1;
                dec.alu    = alu_arith(f3, dp_i_instr[30], dp_i_instr[30]);
                if (f7 == 7'b0000001) begin
`ifdef DECODER_M_EXT_EN
                    dec.muldiv = 1'b1;
                    dec.alu    = '0;
`else
                    dec.exception[EXC_ILLEGAL] = 1'b1;
`endif
                end else if (f7 != 7'b0000000 && f7 != 7'b0100000) begin
                    dec.exception[EXC_ILLEGAL] = 1'b1;
                end
            end
            7'b0010011: begin
                dec.rs1    = AWIDTH'(dp_i_instr[19:15]);
                dec.rd     = AWIDTH'(dp_i_instr[11:7]);
                dec.funct3 = f3;
                dec.imm    = imm_i;
                dec.opcode[OPC_I] = 1'b1;
                dec.alu    = alu_arith(f3, 1'b0, dp_i_instr[30]);
                if ((f3 == 3'b001 || f3 == 3'b101) && dp_i_instr[25])
                    dec.exception[EXC_ILLEGAL] = 1'b1;
            end
            7'b0000011, 7'b1100111: begin
                dec.rs1    = AWIDTH'(dp_i_instr[19:15]);
                dec.rd     = AWIDTH'(dp_i_instr[11:7]);
                dec.funct3 = f3;
                dec.imm    = imm_i;
                dec.opcode[(opc == 7'b0000011) ? OPC_LOAD : OPC_JALR] = 1'b1;
            end
            7'b0100011: begin
                dec.rs1    = AWIDTH'(dp_i_instr[19:15]);
                dec.rs2    = AWIDTH'(dp_i_instr[24:20]);
                dec.funct3 = f3;
                dec.imm    = imm_s;
                dec.opcode[OPC_STORE] = 1'b1;
            end
            7'b1100011: begin
                dec.rs1    = AWIDTH'(dp_i_instr[19:15]);
                dec.rs2    = AWIDTH'(dp_i_instr[24:20]);
                dec.funct3 = f3;
                dec.imm    = imm_b;
                dec.opcode[OPC_BRANCH] = 1'b1;
                dec.alu    = alu_branch(f3);
            end
            7'b1101111: begin
                dec.rd  = AWIDTH'(dp_i_instr[11:7]);
                dec.imm = imm_j;
                dec.opcode[OPC_JAL] = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec.rd  = AWIDTH'(dp_i_instr[11:7]);
                dec.imm = imm_u;
                dec.opcode[(opc == 7'b0110111) ? OPC_LUI : OPC_AUIPC] = 1'b1;
            end
            7'b1110011, 7'b0001111: begin
                dec.rs1    = AWIDTH'(dp_i_instr[19:15]);
                dec.rd     = AWIDTH'(dp_i_instr[11:7]);
                dec.funct3 = f3;
                dec.imm    = imm_z;
                dec.opcode[(opc == 7'b1110011) ? OPC_SYSTEM : OPC_FENCE] = 1'b1;
                if (opc == 7'b1110011 && f3 == 3'b000) begin
                    case (dp_i_instr[31:20])
                        12'h000: dec.exception[EXC_ECALL]   = 1'b1;
                        12'h001: dec.exception[EXC_EBREAK]  = 1'b1;
                        12'h302: dec.exception[EXC_MRET]    = 1'b1;
                        default: dec.exception[EXC_ILLEGAL] = 1'b1;
                    endcase
                end
            end
            default: dec.exception[EXC_ILLEGAL] = 1'b1;
        endcase
        // An illegal instruction is queued but carries no instruction class.
        if (dec.exception[EXC_ILLEGAL])
            dec.opcode = '0;
    end

    assign dp_o_ready = (count < DEPTH_C);
    assign dp_o_valid = (count != '0);
    assign push       = dp_i_valid && dp_o_ready;
    assign pop        = dp_o_valid && dp_i_ready;
    assign dp_o_count = count;

    // Record storage; only pointers and occupancy need reset since the head is gated.
    always_ff @(posedge dp_clk) begin
        if (push)
            mem[wr_ptr] <= dec;
    end

    // Pointer and occupancy update; flush overrides any same-cycle push or pop.
    always_ff @(posedge dp_clk or negedge dp_rst) begin
        if (!dp_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (dp_i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head           = dp_o_valid ? mem[rd_ptr] : '0;
    assign dp_o_pc        = head.pc;
    assign dp_o_addr_rs1  = head.rs1;
    assign dp_o_addr_rs2  = head.rs2;
    assign dp_o_addr_rd   = head.rd;
    assign dp_o_imm       = head.imm;
    assign dp_o_funct3    = head.funct3;
    assign dp_o_alu       = head.alu;
    assign dp_o_opcode    = head.opcode;
    assign dp_o_exception = head.exception;
    assign dp_o_muldiv    = head.muldiv;

endmodule

// File: tb/tb_decoder_pipe.sv
// Testbench for decoder_pipe: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
`timescale 1ns/1ps

module tb_decoder_pipe;

    localparam int XLEN   = 32;
    localparam int AWIDTH = 5;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4, A_OR = 5;
    localparam int A_AND = 6, A_SLL = 7, A_SRL = 8, A_SRA = 9, A_EQ = 10, A_NEQ = 11;
    localparam int A_GE = 12, A_GEU = 13;
    localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4, C_JAL = 5;
    localparam int C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_SYSTEM = 9, C_FENCE = 10;
    localparam int E_ILL = 0, E_ECALL = 1, E_EBREAK = 2, E_MRET = 3;
    localparam int F_N = 0, F_R = 1, F_I = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6, F_Z = 7;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [13:0] alu;
        logic [10:0] opc;
        logic [3:0]  exc;
        logic        md;
    } rec_t;
    localparam int RW = $bits(rec_t);

    logic              dp_clk, dp_rst;
    logic              dp_i_valid, dp_o_ready, dp_o_valid, dp_i_ready, dp_i_flush;
    logic [31:0]       dp_i_instr;
    logic [XLEN-1:0]   dp_i_pc, dp_o_pc, dp_o_imm;
    logic [AWIDTH-1:0] dp_o_addr_rs1, dp_o_addr_rs2, dp_o_addr_rd;
    logic [2:0]        dp_o_funct3;
    logic [13:0]       dp_o_alu;
    logic [10:0]       dp_o_opcode;
    logic [3:0]        dp_o_exception;
    logic              dp_o_muldiv;
    logic [CW-1:0]     dp_o_count;

    logic [RW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    decoder_pipe #(.XLEN(XLEN), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
        .dp_clk(dp_clk), .dp_rst(dp_rst),
        .dp_i_valid(dp_i_valid), .dp_o_ready(dp_o_ready),
        .dp_i_instr(dp_i_instr), .dp_i_pc(dp_i_pc),
        .dp_o_valid(dp_o_valid), .dp_i_ready(dp_i_ready), .dp_i_flush(dp_i_flush),
        .dp_o_pc(dp_o_pc), .dp_o_addr_rs1(dp_o_addr_rs1), .dp_o_addr_rs2(dp_o_addr_rs2),
        .dp_o_addr_rd(dp_o_addr_rd), .dp_o_imm(dp_o_imm), .dp_o_funct3(dp_o_funct3),
        .dp_o_alu(dp_o_alu), .dp_o_opcode(dp_o_opcode), .dp_o_exception(dp_o_exception),
        .dp_o_muldiv(dp_o_muldiv), .dp_o_count(dp_o_count)
    );

    // Clock
    initial dp_clk = 1'b0;
    always #5 dp_clk = ~dp_clk;

    // Reference decode, written from the ISA encoding rules.
    function automatic rec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        rec_t r;
        int fmt, cls, alu_idx, si;
        logic ill;
        int arith_tbl [8];
        int br_tbl [8];
        arith_tbl = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        br_tbl    = '{A_EQ, A_NEQ, -1, -1, A_SLT, A_GE, A_SLTU, A_GEU};
        r = '0;
        r.pc = pc;
        si = $signed(ins);
        ill = 1'b0;
        cls = -1;
        fmt = F_N;
        case (ins[6:0])
            7'h33: begin cls = C_R;      fmt = F_R; end
            7'h13: begin cls = C_I;      fmt = F_I; end
            7'h03: begin cls = C_LOAD;   fmt = F_I; end
            7'h67: begin cls = C_JALR;   fmt = F_I; end
            7'h23: begin cls = C_STORE;  fmt = F_S; end
            7'h63: begin cls = C_BRANCH; fmt = F_B; end
            7'h6f: begin cls = C_JAL;    fmt = F_J; end
            7'h37: begin cls = C_LUI;    fmt = F_U; end
            7'h17: begin cls = C_AUIPC;  fmt = F_U; end
            7'h73: begin cls = C_SYSTEM; fmt = F_Z; end
            7'h0f: begin cls = C_FENCE;  fmt = F_Z; end
            default: ill = 1'b1;
        endcase
        if (fmt inside {F_R, F_I, F_S, F_B, F_Z}) r.rs1 = ins[19:15];
        if (fmt inside {F_R, F_S, F_B})           r.rs2 = ins[24:20];
        if (fmt inside {F_R, F_I, F_U, F_J, F_Z}) r.rd  = ins[11:7];
        if (fmt inside {F_R, F_I, F_S, F_B, F_Z}) r.f3  = ins[14:12];
        case (fmt)
            F_I: r.imm = si >>> 20;
            F_S: r.imm = (si >>> 25) * 32 + int'(ins[11:7]);
            F_B: r.imm = (si >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                         + int'(ins[11:8]) * 2;
            F_U: r.imm = ins & 32'hFFFF_F000;
            F_J: r.imm = (si >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                         + int'(ins[30:21]) * 2;
            F_Z: r.imm = ins >> 20;
            default: r.imm = '0;
        endcase
        alu_idx = A_ADD;
        if (cls == C_R || cls == C_I) begin
            alu_idx = arith_tbl[ins[14:12]];
            if (ins[14:12] == 3'd0 && cls == C_R && ins[30]) alu_idx = A_SUB;
            if (ins[14:12] == 3'd5 && ins[30]) alu_idx = A_SRA;
        end else if (cls == C_BRANCH) begin
            alu_idx = br_tbl[ins[14:12]];
        end
        if (alu_idx >= 0) r.alu[alu_idx] = 1'b1;
        if (cls == C_I && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) && ins[25]) ill = 1'b1;
        if (cls == C_R) begin
            if (ins[31:25] == 7'h01) begin
`ifdef DECODER_M_EXT_EN
                r.md  = 1'b1;
                r.alu = '0;
`else
                ill = 1'b1;
`endif
            end else if (ins[31:25] != 7'h00 && ins[31:25] != 7'h20) begin
                ill = 1'b1;
            end
        end
        if (cls == C_SYSTEM && ins[14:12] == 3'd0) begin
            if (ins[31:20] == 12'h000)      r.exc[E_ECALL] = 1'b1;
            else if (ins[31:20] == 12'h001) r.exc[E_EBREAK] = 1'b1;
            else if (ins[31:20] == 12'h302) r.exc[E_MRET] = 1'b1;
            else ill = 1'b1;
        end
        r.exc[E_ILL] = ill;
        if (!ill && cls >= 0) r.opc[cls] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0] ops [11];
        int k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0f};
        r = $urandom();
        k = $urandom_range(0, 15);
        if (k <= 10) begin
            r[6:0] = ops[k];
        end else if (k <= 12) begin
            r[6:0] = 7'h33;
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: r[31:25] = r[31:25];
            endcase
        end else if (k == 13) begin
            r[6:0] = 7'h73;
            r[14:12] = 3'd0;
            case ($urandom_range(0, 3))
                0: r[31:20] = 12'h000;
                1: r[31:20] = 12'h001;
                2: r[31:20] = 12'h302;
                default: r[31:20] = r[31:20];
            endcase
        end else if (k == 14) begin
            r[6:0] = 7'h13;
            r[14:12] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle scoreboard compare of all DUT outputs against the model.
    task automatic compare_cycle();
        rec_t exp_r, act_r;
        int n;
        n = exp_q.size();
        exp_r = (n != 0) ? rec_t'(exp_q[0]) : rec_t'('0);
        act_r = {dp_o_pc, dp_o_addr_rs1, dp_o_addr_rs2, dp_o_addr_rd, dp_o_imm, dp_o_funct3,
                 dp_o_alu, dp_o_opcode, dp_o_exception, dp_o_muldiv};
        checks++;
        if (dp_o_valid !== (n != 0) || dp_o_ready !== (n < DEPTH) ||
            dp_o_count !== CW'(n) || act_r !== exp_r) begin
            errors++;
            $display("FAIL cycle t=%0t valid=%b/%b ready=%b count=%0d/%0d rec=%h/%h",
                     $time, dp_o_valid, (n != 0), dp_o_ready, dp_o_count, n, act_r, exp_r);
        end
    endtask

    // Model step using the inputs that the coming rising edge will see.
    task automatic model_update();
        logic do_pop, do_push;
        if (!dp_rst || dp_i_flush) begin
            exp_q.delete();
        end else begin
            do_pop  = (exp_q.size() != 0) && dp_i_ready;
            do_push = dp_i_valid && (exp_q.size() < DEPTH);
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(ref_decode(dp_i_instr, dp_i_pc));
        end
    endtask

    task automatic cycle();
        @(negedge dp_clk);
        if (dp_rst) compare_cycle();
        model_update();
        @(posedge dp_clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
        dp_i_valid = 1'b1;
        dp_i_instr = ins;
        dp_i_pc    = pc;
        cycle();
        dp_i_valid = 1'b0;
    endtask

    task automatic pop1();
        dp_i_ready = 1'b1;
        cycle();
        dp_i_ready = 1'b0;
    endtask

    rec_t m;

    initial begin
        dp_rst = 1'b0; dp_i_valid = 1'b0; dp_i_ready = 1'b0; dp_i_flush = 1'b0;
        dp_i_instr = '0; dp_i_pc = '0;
        cycle();
        cycle();
        check("rst_valid", dp_o_valid, 0);
        check("rst_count", dp_o_count, 0);
        check("rst_opcode", dp_o_opcode, 0);
        check("rst_alu", dp_o_alu, 0);
        dp_rst = 1'b1;
        cycle();
        check("rst_ready", dp_o_ready, 1);

        // addi x1,x0,5
        push1(32'h0050_0093, 32'h100);
        check("addi_valid", dp_o_valid, 1);
        check("addi_pc", dp_o_pc, 32'h100);
        check("addi_rd", dp_o_addr_rd, 1);
        check("addi_rs1", dp_o_addr_rs1, 0);
        check("addi_rs2", dp_o_addr_rs2, 0);
        check("addi_imm", dp_o_imm, 5);
        check("addi_alu", dp_o_alu, 14'd1 << A_ADD);
        check("addi_opc", dp_o_opcode, 11'd1 << C_I);
        check("model_nonempty", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            m = exp_q[0];
            check("model_addi_imm", m.imm, 5);
            check("model_addi_rd", m.rd, 1);
        end
        pop1();

        // beq x1,x2,+8
        push1(32'h0020_8463, 32'h104);
        check("beq_rs1", dp_o_addr_rs1, 1);
        check("beq_rs2", dp_o_addr_rs2, 2);
        check("beq_rd", dp_o_addr_rd, 0);
        check("beq_imm", dp_o_imm, 8);
        check("beq_alu", dp_o_alu, 14'd1 << A_EQ);
        check("beq_opc", dp_o_opcode, 11'd1 << C_BRANCH);
        if (exp_q.size() != 0) begin
            m = exp_q[0];
            check("model_beq_imm", m.imm, 8);
        end
        pop1();

        // ecall then an all-ones word
        push1(32'h0000_0073, 32'h108);
        push1(32'hFFFF_FFFF, 32'h10C);
        check("ecall_exc", dp_o_exception, 4'd1 << E_ECALL);
        check("ecall_opc", dp_o_opcode, 11'd1 << C_SYSTEM);
        pop1();
        check("ill_exc", dp_o_exception, 4'd1 << E_ILL);
        check("ill_opc", dp_o_opcode, 0);
        pop1();

        // mul x3,x1,x2
        push1(32'h0220_81B3, 32'h110);
`ifdef DECODER_M_EXT_EN
        check("mul_muldiv", dp_o_muldiv, 1);
        check("mul_exc", dp_o_exception, 0);
        check("mul_alu", dp_o_alu, 0);
        check("mul_f3", dp_o_funct3, 0);
        check("mul_rd", dp_o_addr_rd, 3);
`else
        check("mul_exc", dp_o_exception, 4'd1 << E_ILL);
        check("mul_muldiv", dp_o_muldiv, 0);
        check("mul_opc", dp_o_opcode, 0);
`endif
        pop1();

        // Fill to DEPTH with consumer stalled, then one extra attempt
        for (int i = 0; i <= DEPTH; i++) begin
            push1(32'h0050_0093 + (i << 7), 32'h200 + 4 * i);
            if (i == DEPTH - 1) begin
                check("full_ready", dp_o_ready, 0);
                check("full_count", dp_o_count, DEPTH);
            end
        end
        check("full_hold_count", dp_o_count, DEPTH);
        check("full_hold_pc", dp_o_pc, 32'h200);
        for (int i = 0; i < DEPTH; i++) begin
            check("fifo_order_pc", dp_o_pc, 32'h200 + 4 * i);
            pop1();
        end
        check("drained_valid", dp_o_valid, 0);

        // Flush with three queued and a simultaneous push
        for (int i = 0; i < 3; i++) push1(32'h0010_0113, 32'h300 + 4 * i);
        check("preflush_count", dp_o_count, 3);
        dp_i_flush = 1'b1;
        push1(32'h0020_0193, 32'h30C);
        dp_i_flush = 1'b0;
        check("flush_count", dp_o_count, 0);
        check("flush_valid", dp_o_valid, 0);

        // Reset in the middle of operation
        push1(32'h0050_0093, 32'h400);
        push1(32'h0050_0093, 32'h404);
        dp_rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_valid", dp_o_valid, 0);
        check("midrst_count", dp_o_count, 0);
        check("midrst_pc", dp_o_pc, 0);
        cycle();
        dp_rst = 1'b1;
        push1(32'h0050_0093, 32'h500);
        check("postrst_count", dp_o_count, 1);
        check("postrst_pc", dp_o_pc, 32'h500);
        pop1();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                dp_rst = 1'b0;
                exp_q.delete();
                cycle();
                dp_rst = 1'b1;
            end
            dp_i_valid = ($urandom_range(0, 99) < 70);
            dp_i_ready = ($urandom_range(0, 99) < 60);
            dp_i_flush = ($urandom_range(0, 99) < 3);
            dp_i_instr = rand_instr();
            dp_i_pc    = $urandom() & 32'hFFFF_FFFC;
            cycle();
        end
        dp_i_valid = 1'b0;
        dp_i_flush = 1'b0;
        dp_i_ready = 1'b1;
        repeat (DEPTH + 1) cycle();
        check("final_empty", dp_o_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
